seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//   Run controller for serial pattern detection. Latches a programmable pattern/length/window on
//   start, runs over a bounded window of valid input bits and counts matches (overlapping or
//   non-overlapping). Reports a match pulse per hit and done at the end of the run.
//   Sits between the host/config logic and the serial din stream.
// PARAMETERS
//   PAT_W  8   max pattern length in bits; cfg_len range 1..PAT_W
//   LEN_W  4   width of cfg_len; must hold PAT_W ($clog2(PAT_W)+1)
//   WIN_W  16  width of window (bit-count) config and counter
//   CNT_W  8   width of match counter
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      run request, sampled only in IDLE
//   abort        in   1      stop run (RUN only); no done
//   cfg_pattern  in   PAT_W  pattern; bit [cfg_len-1] is first bit received, bit [0] is last
//   cfg_len      in   LEN_W  pattern length
//   cfg_window   in   WIN_W  number of valid bits to consume per run
//   cfg_overlap  in   1      1 = overlapping matches, 0 = history cleared after each match
//   din          in   1      serial data bit
//   din_valid    in   1      din is consumed this cycle (RUN only)
//   busy         out  1      high in RUN
//   match        out  1      1-cycle pulse, cycle after the bit completing a match
//   done         out  1      1-cycle pulse in DONE
//   err          out  1      1-cycle pulse, cycle after a rejected start
//   match_cnt    out  CNT_W  matches in current/last run; saturating
// BEHAVIOUR
//   - Reset: state IDLE; busy/match/done/err=0; match_cnt=0; history/fill/window counters=0.
//   - States: IDLE -> RUN (start, valid cfg) | IDLE (start, invalid cfg: err=1);
//     RUN -> DONE (window complete or limit hit) | IDLE (abort); DONE -> IDLE (always, 1 cycle).
//   - Valid cfg: 1 <= cfg_len <= PAT_W and cfg_window != 0. All cfg latched on the accepted start
//     edge; cfg changes during RUN ignored. On accept, match_cnt, history and counters clear.
//   - start in RUN/DONE ignored. abort outside RUN ignored.
//   - RUN, din_valid=1: hist <= {hist[PAT_W-2:0],din}; fill <= min(fill+1,PAT_W); bits++.
//     Hit when fill_next >= len and hist_next[len-1:0] == pattern[len-1:0].
//     On hit: match=1 next cycle; match_cnt+1 (holds at all-ones); if !overlap, fill <= 0.
//   - din_valid=0: nothing changes; no timeout.
//   - Last window bit: same edge -> DONE; a hit on that bit gives match and done in the same cycle.
//   - abort with din_valid in the same cycle: abort wins, bit not consumed; match_cnt retained.
//   - busy is decoded from the registered state, so it is high from the cycle after start.
//   - Latency: bit -> match = 1 cycle. Start -> busy = 1 cycle.
//   - rst_n low mid-run: immediate return to reset values; no done.
// CONFIGURATION
//   SEQ_MATCH_LIMIT_EN defined:
//     - Adds input cfg_limit [CNT_W-1:0], latched on start; 0 = no limit.
//     - Adds output limit_hit [1]: set in DONE when the run ended by limit; cleared on next accepted start.
//     - When match_cnt_next == cfg_limit (nonzero): go to DONE on that edge, ignoring remaining window.
//   SEQ_MATCH_LIMIT_EN undefined: ports absent; runs end only by window or abort.
// STRUCTURE
//   - Package seq_ctrl_pkg: state typedef (IDLE, RUN, DONE), default widths, cfg-valid helper function.
//   - Sub-module seq_match_core: history shift register, fill counter, masked compare,
//     overlap clear; outputs a combinational hit.
//   - Top level: FSM, window counter, match counter, output registers.
// TESTING
//   - pattern=5'b10110 len=5 overlap=1 window=8, din 1,0,1,1,0,1,1,0 -> match after bits 5 and 8; match_cnt=2; done with 2nd match.
//   - Same stream, overlap=0 -> one match (after bit 5); match_cnt=1; done after bit 8.
//   - start with cfg_len=0 or cfg_window=0 -> err pulse; busy stays 0; match_cnt unchanged.
//   - len=3 pattern 101 window=10, abort after 4 bits (din_valid=1 on abort cycle) -> IDLE, no done, bit 5 not consumed.
//   - len=1 pattern 1, window=300 all ones -> match_cnt saturates at 255; done after bit 300.
//   - SEQ_MATCH_LIMIT_EN, cfg_limit=2, len=1 pattern 1, window=10 -> done after 2nd one; limit_hit=1.
//   - Gaps: din_valid toggled 1/0 during a 10110 run -> same counts as the contiguous stream.
//   - rst_n low during RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// ============================================================================
// Module   : seq_ctrl_pkg
// Purpose  : Shared types and helpers for the serial pattern-detect run
//            controller: FSM state encoding, default widths and the
//            configuration validity check.
// Ports    : none (package)
// Options  : SEQ_MATCH_LIMIT_EN is consumed by seq_detect_ctrl only.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_ctrl_pkg;

  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_LEN_W = 4;
  localparam int unsigned DEF_WIN_W = 16;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A run is accepted only with a pattern length of 1..pat_w and a
  // non-empty window.
  function automatic logic cfg_valid(input int unsigned len,
                                     input int unsigned pat_w,
                                     input logic        win_nz);
    return (len >= 1) && (len <= pat_w) && win_nz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// ============================================================================
// Module   : seq_match_core
// Purpose  : History shift register, fill counter and masked compare for
//            the serial pattern detector.
// Ports    : clk, rst_n        clock, async active-low reset
//            clear_i           clear history and fill (run accepted)
//            shift_i           consume din_i this cycle
//            din_i             serial data bit
//            pattern_i/len_i   latched pattern and its length
//            overlap_i         1 = keep fill after a hit
//            hit_o             combinational: din_i completes a match
//                              (meaningful when shift_i is high)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             din_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             overlap_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0] mask;

  always_comb begin
    mask     = '0;
    hist_d   = {hist_q[PAT_W-2:0], din_i};
    // fill tracks how many valid history bits exist, capped at PAT_W
    fill_inc = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len_i);
    end
    hit_o  = (fill_inc >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
    // Non-overlapping mode restarts the fill so old bits cannot be reused
    fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Run controller for serial pattern detection. Latches the
//            configuration on an accepted start, consumes a bounded window
//            of valid bits, counts matches and signals done.
// Ports    : clk, rst_n                 clock, async active-low reset
//            start, abort               run request / run stop
//            cfg_pattern, cfg_len,
//            cfg_window, cfg_overlap    run configuration
//            din, din_valid             serial input stream
//            busy, match, done, err     status (match/done/err are pulses)
//            match_cnt                  saturating match count
//            cfg_limit, limit_hit       only with SEQ_MATCH_LIMIT_EN
// Options  : SEQ_MATCH_LIMIT_EN - adds a match-count limit that ends a run
//            early.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned WIN_W = DEF_WIN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             cfg_overlap,
`ifdef SEQ_MATCH_LIMIT_EN
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             limit_hit,
`endif
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [WIN_W-1:0] window_q;
  logic             overlap_q;
  logic [WIN_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             accept;
  logic             shift;
  logic             hit;
  logic             start_ok;
`ifdef SEQ_MATCH_LIMIT_EN
  logic [CNT_W-1:0] limit_q;
  logic             limhit_q, limhit_d;
  logic             lim_reached;
`endif

  assign start_ok = cfg_valid(32'(cfg_len), PAT_W, |cfg_window);
  // abort takes priority over a bit offered in the same cycle
  assign shift    = (state_q == ST_RUN) && din_valid && !abort;

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept),
    .shift_i   (shift),
    .din_i     (din),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .hit_o     (hit)
  );

  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    cnt_d    = cnt_q;
    match_d  = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
`ifdef SEQ_MATCH_LIMIT_EN
    limhit_d    = limhit_q;
    lim_reached = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            accept  = 1'b1;
            state_d = ST_RUN;
            bits_d  = '0;
            cnt_d   = '0;
`ifdef SEQ_MATCH_LIMIT_EN
            limhit_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (din_valid) begin
          bits_d = bits_q + WIN_W'(1);
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
`ifdef SEQ_MATCH_LIMIT_EN
          lim_reached = hit && (limit_q != '0) && (cnt_d == limit_q);
          if (lim_reached) begin
            limhit_d = 1'b1;
            state_d  = ST_DONE;
          end
`endif
          if (bits_q == window_q - WIN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bits_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_MATCH_LIMIT_EN
      limhit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
`ifdef SEQ_MATCH_LIMIT_EN
      limhit_q <= limhit_d;
`endif
    end
  end

  // Configuration is frozen for the whole run once a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      window_q  <= '0;
      overlap_q <= 1'b0;
`ifdef SEQ_MATCH_LIMIT_EN
      limit_q   <= '0;
`endif
    end else if (accept) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      window_q  <= cfg_window;
      overlap_q <= cfg_overlap;
`ifdef SEQ_MATCH_LIMIT_EN
      limit_q   <= cfg_limit;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign match     = match_q;
  assign err       = err_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_MATCH_LIMIT_EN
  assign limit_hit = limhit_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Directed self-checking bench for seq_detect_ctrl.
// Options  : SEQ_MATCH_LIMIT_EN enables the match-limit scenario.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, din, din_valid, cfg_overlap;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_window;
  logic        busy, match, done, err;
  logic [7:0]  match_cnt;
`ifdef SEQ_MATCH_LIMIT_EN
  logic [7:0]  cfg_limit;
  logic        limit_hit;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_window  (cfg_window),
    .cfg_overlap (cfg_overlap),
`ifdef SEQ_MATCH_LIMIT_EN
    .cfg_limit   (cfg_limit),
    .limit_hit   (limit_hit),
`endif
    .din         (din),
    .din_valid   (din_valid),
    .busy        (busy),
    .match       (match),
    .done        (done),
    .err         (err),
    .match_cnt   (match_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] pat, input logic [3:0] len,
                           input logic [15:0] win, input logic ovl);
    cfg_pattern = pat; cfg_len = len; cfg_window = win; cfg_overlap = ovl;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({match, done, err} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {match, done, err}); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", match_cnt); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_stream(input logic ovl, input logic gaps, input logic [7:0] em, input logic [7:0] ecnt);
    logic [7:0] s;
    s = 8'b1011_0110;
    start_run(8'b0001_0110, 4'd5, 16'd8, ovl);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL str_busy got=%b exp=1", busy); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL str_cnt0 got=%0d exp=0", match_cnt); end
    // cfg changes mid-run must have no effect
    cfg_len = 4'd2; cfg_pattern = 8'hFF; cfg_overlap = ~ovl;
    for (int i = 0; i < 8; i++) begin
      din = s[7-i]; din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      total++; if (match !== em[i]) begin bad++; $display("FAIL str_match ovl=%0b bit%0d got=%b exp=%b", ovl, i + 1, match, em[i]); end
      total++; if (done !== (i == 7)) begin bad++; $display("FAIL str_done ovl=%0b bit%0d got=%b exp=%b", ovl, i + 1, done, (i == 7)); end
      if (gaps && i != 7) begin
        din = ~din;
        tick;
        total++; if (match !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gap_idle bit%0d got m=%b b=%b exp m=0 b=1", i + 1, match, busy); end
      end
    end
    total++; if (match_cnt !== ecnt) begin bad++; $display("FAIL str_cnt ovl=%0b got=%0d exp=%0d", ovl, match_cnt, ecnt); end
    tick;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL str_end got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_bad_cfg;
    logic [3:0]  lens [3];
    logic [15:0] wins [3];
    lens = '{4'd0, 4'd5, 4'd9};
    wins = '{16'd8, 16'd0, 16'd8};
    for (int k = 0; k < 3; k++) begin
      start_run(8'h16, lens[k], wins[k], 1'b1);
      total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bad_cfg%0d got err=%b busy=%b exp err=1 busy=0", k, err, busy); end
      total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL bad_cnt%0d got=%0d exp=1", k, match_cnt); end
      tick;
      total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bad_pulse%0d got err=%b busy=%b exp 0 0", k, err, busy); end
    end
  endtask

  task automatic test_abort;
    logic [3:0] s;
    s = 4'b1010;
    start_run(8'b101, 4'd3, 16'd10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      din = s[3-i]; din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      total++; if (match !== (i == 2)) begin bad++; $display("FAIL abt_match bit%0d got=%b exp=%b", i + 1, match, (i == 2)); end
    end
    din = 1'b1; din_valid = 1'b1; abort = 1'b1;
    tick;
    din_valid = 1'b0; abort = 1'b0;
    total++; if ({busy, match, done} !== 3'b000) begin bad++; $display("FAIL abt_state got=%b exp=000", {busy, match, done}); end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL abt_cnt got=%0d exp=1", match_cnt); end
    tick;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abt_nodone got=%b exp=0", done); end
  endtask

  task automatic test_saturate;
    start_run(8'b1, 4'd1, 16'd300, 1'b1);
    for (int i = 0; i < 300; i++) begin
      din = 1'b1; din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      if (i == 253) begin
        total++; if (match_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", match_cnt); end
      end
      if (i == 298) begin
        total++; if (done !== 1'b0 || match_cnt !== 8'd255) begin bad++; $display("FAIL sat_299 got done=%b cnt=%0d exp 0 255", done, match_cnt); end
      end
    end
    total++; if ({done, match} !== 2'b11) begin bad++; $display("FAIL sat_done got=%b exp=11", {done, match}); end
    total++; if (match_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", match_cnt); end
    tick;
  endtask

`ifdef SEQ_MATCH_LIMIT_EN
  task automatic test_limit;
    cfg_limit = 8'd2;
    start_run(8'b1, 4'd1, 16'd10, 1'b1);
    total++; if (limit_hit !== 1'b0) begin bad++; $display("FAIL lim_clear got=%b exp=0", limit_hit); end
    din = 1'b1; din_valid = 1'b1;
    tick;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lim_early got=%b exp=0", done); end
    tick;
    din_valid = 1'b0;
    total++; if ({done, match, limit_hit} !== 3'b111) begin bad++; $display("FAIL lim_done got=%b exp=111", {done, match, limit_hit}); end
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL lim_cnt got=%0d exp=2", match_cnt); end
    tick;
    total++; if ({busy, limit_hit} !== 2'b01) begin bad++; $display("FAIL lim_hold got=%b exp=01", {busy, limit_hit}); end
    cfg_limit = 8'd0;
  endtask
`endif

  task automatic test_reset_mid_run;
    start_run(8'b1, 4'd1, 16'd10, 1'b1);
    din = 1'b1; din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    total++; if ({busy, match, match_cnt} !== {2'b11, 8'd1}) begin bad++; $display("FAIL mid_pre got b=%b m=%b c=%0d exp 1 1 1", busy, match, match_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, match, done, err} !== 4'b0000 || match_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst got=%b cnt=%0d exp 0000 0", {busy, match, done, err}, match_cnt); end
    #2 rst_n = 1'b1;
    tick;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mid_after got=%b exp=00", {busy, done}); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_window = '0; cfg_overlap = 1'b0;
`ifdef SEQ_MATCH_LIMIT_EN
    cfg_limit = '0;
`endif
    test_reset;
    test_stream(1'b1, 1'b0, 8'b1001_0000, 8'd2);
    test_stream(1'b0, 1'b0, 8'b0001_0000, 8'd1);
    test_bad_cfg;
    test_abort;
    test_saturate;
    test_stream(1'b1, 1'b1, 8'b1001_0000, 8'd2);
`ifdef SEQ_MATCH_LIMIT_EN
    test_limit;
`endif
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
